stimulus_seq: RTL and testbench

STIMULUS_SEQ -- requirements
Module: stimulus_seq

---
 rtl/stimulus_seq.sv | 218 +++++++++++++++++++++
 tb/tb_stimulus_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stimulus_seq.sv
// Stimulus sequencer: sweeps sub modes of one main mode, driving per-channel
// control words, power-on-reset pulses and a measurement window for each step.
module stimulus_seq #(
  parameter int NCH        = 4,
  parameter int CW         = 14,
  parameter int DW         = 16,
  parameter int POR_CYC    = 8,
  parameter int SETTLE_CYC = 16
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              START,
  input  logic              ABORT,
  input  logic [7:0]        MAIN_MODE,
  input  logic [7:0]        SUB_START,
  input  logic [7:0]        SUB_END,
  input  logic [NCH-1:0]    CH_EN,
  input  logic [DW-1:0]     DWELL,
  output logic [15:0]       TBL_MODE,
  input  logic [CW-1:0]     TBL_A,
  input  logic [CW-1:0]     TBL_B,
  input  logic              TBL_OK,
  output logic [NCH*CW-1:0] A_CTRL,
  output logic [NCH*CW-1:0] B_CTRL,
  output logic [NCH-1:0]    POR,
  output logic              MEAS_EN,
  output logic [7:0]        CUR_SUB,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [7:0]        SKIP_CNT
);

  localparam int CNTW = (DW > 16) ? DW : 16;

  typedef enum logic [2:0] {IDLE, LOAD, PORS, SETTLE, MEAS, NEXT, FIN} state_t;

  state_t            state, state_nx;
  logic [7:0]        main_q, main_nx;
  logic [7:0]        sub_end_q, sub_end_nx;
  logic [NCH-1:0]    ch_en_q, ch_en_nx;
  logic [DW-1:0]     dwell_q, dwell_nx;
  logic [CNTW-1:0]   cnt, cnt_nx;
  logic [NCH*CW-1:0] a_nx, b_nx, a_load, b_load;
  logic [NCH-1:0]    por_nx;
  logic              meas_nx, busy_nx, done_nx, err_nx;
  logic [7:0]        cur_sub_nx, skip_nx;
  logic [15:0]       tbl_nx;

  // Every output is computed here for the state being entered, then registered,
  // so the registered outputs always describe the state the block is in.
  always_comb begin
    state_nx   = state;
    main_nx    = main_q;
    sub_end_nx = sub_end_q;
    ch_en_nx   = ch_en_q;
    dwell_nx   = dwell_q;
    cnt_nx     = cnt;
    a_nx       = A_CTRL;
    b_nx       = B_CTRL;
    por_nx     = POR;
    meas_nx    = MEAS_EN;
    cur_sub_nx = CUR_SUB;
    done_nx    = 1'b0;
    err_nx     = ERR;
    skip_nx    = SKIP_CNT;
    tbl_nx     = TBL_MODE;
    a_load     = '0;
    b_load     = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_en_q[k]) begin
        a_load[k*CW +: CW] = TBL_A;
        b_load[k*CW +: CW] = TBL_B;
      end
    end

    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          main_nx    = MAIN_MODE;
          sub_end_nx = SUB_END;
          ch_en_nx   = CH_EN;
          dwell_nx   = DWELL;
          cur_sub_nx = SUB_START;
          tbl_nx     = {MAIN_MODE, SUB_START};
          err_nx     = 1'b0;
          skip_nx    = 8'd0;
          if (SUB_END < SUB_START) begin
            err_nx   = 1'b1;
            done_nx  = 1'b1;
            state_nx = FIN;
          end else begin
            state_nx = LOAD;
          end
        end
      end
      LOAD: begin
        if (TBL_OK) begin
          a_nx     = a_load;
          b_nx     = b_load;
          por_nx   = '1;
          cnt_nx   = CNTW'(POR_CYC - 1);
          state_nx = PORS;
        end else begin
          err_nx   = 1'b1;
          if (SKIP_CNT != 8'hFF) skip_nx = SKIP_CNT + 8'd1;
          a_nx     = '0;
          b_nx     = '0;
          por_nx   = '1;
          state_nx = NEXT;
        end
      end
      PORS: begin
        if (cnt == '0) begin
          por_nx   = ~ch_en_q;
          cnt_nx   = CNTW'(SETTLE_CYC - 1);
          state_nx = SETTLE;
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          meas_nx  = 1'b1;
          cnt_nx   = (dwell_q == '0) ? '0 : CNTW'(dwell_q) - CNTW'(1);
          state_nx = MEAS;
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      MEAS: begin
        if (cnt == '0) begin
          meas_nx  = 1'b0;
          state_nx = NEXT;
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      NEXT: begin
        a_nx   = '0;
        b_nx   = '0;
        por_nx = '1;
        if (CUR_SUB == sub_end_q) begin
          done_nx  = 1'b1;
          state_nx = FIN;
        end else begin
          cur_sub_nx = CUR_SUB + 8'd1;
          tbl_nx     = {main_q, CUR_SUB + 8'd1};
          state_nx   = LOAD;
        end
      end
      FIN: begin
        a_nx     = '0;
        b_nx     = '0;
        por_nx   = '1;
        meas_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Abort wins over whatever the active state decided, leaving error status as it was.
    if (ABORT && state != IDLE && state != FIN) begin
      state_nx   = FIN;
      done_nx    = 1'b1;
      a_nx       = '0;
      b_nx       = '0;
      por_nx     = '1;
      meas_nx    = 1'b0;
      err_nx     = ERR;
      skip_nx    = SKIP_CNT;
      cur_sub_nx = CUR_SUB;
      tbl_nx     = TBL_MODE;
      cnt_nx     = cnt;
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state     <= IDLE;
      main_q    <= 8'd0;
      sub_end_q <= 8'd0;
      ch_en_q   <= '0;
      dwell_q   <= '0;
      cnt       <= '0;
      A_CTRL    <= '0;
      B_CTRL    <= '0;
      POR       <= '1;
      MEAS_EN   <= 1'b0;
      CUR_SUB   <= 8'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      SKIP_CNT  <= 8'd0;
      TBL_MODE  <= 16'd0;
    end else begin
      state     <= state_nx;
      main_q    <= main_nx;
      sub_end_q <= sub_end_nx;
      ch_en_q   <= ch_en_nx;
      dwell_q   <= dwell_nx;
      cnt       <= cnt_nx;
      A_CTRL    <= a_nx;
      B_CTRL    <= b_nx;
      POR       <= por_nx;
      MEAS_EN   <= meas_nx;
      CUR_SUB   <= cur_sub_nx;
      BUSY      <= busy_nx;
      DONE      <= done_nx;
      ERR       <= err_nx;
      SKIP_CNT  <= skip_nx;
      TBL_MODE  <= tbl_nx;
    end
  end

endmodule

// File: tb/tb_stimulus_seq.sv
// Directed bench for stimulus_seq: sweeps, unsupported modes, range error,
// abort, top-of-range sweep and mid-sweep reset.
module tb_stimulus_seq;
  localparam int NCH = 4;
  localparam int CW  = 14;
  localparam int DW  = 16;

  logic              CLK = 1'b0;
  logic              RSTX, START, ABORT, TBL_OK;
  logic [7:0]        MAIN_MODE, SUB_START, SUB_END;
  logic [NCH-1:0]    CH_EN;
  logic [DW-1:0]     DWELL;
  logic [15:0]       TBL_MODE;
  logic [CW-1:0]     TBL_A, TBL_B;
  logic [NCH*CW-1:0] A_CTRL, B_CTRL;
  logic [NCH-1:0]    POR;
  logic              MEAS_EN, BUSY, DONE, ERR;
  logic [7:0]        CUR_SUB, SKIP_CNT;

  int n_checks = 0;
  int n_errors = 0;

  logic       bad_en  = 1'b0;
  logic [7:0] bad_sub = 8'd0;

  // External mode table: A encodes sub+100, B echoes the lookup address.
  assign TBL_A  = CW'(TBL_MODE[7:0]) + CW'(100);
  assign TBL_B  = TBL_MODE[13:0];
  assign TBL_OK = !(bad_en && TBL_MODE[7:0] == bad_sub);

  always #5 CLK = ~CLK;

  stimulus_seq dut (
    .CLK(CLK), .RSTX(RSTX), .START(START), .ABORT(ABORT),
    .MAIN_MODE(MAIN_MODE), .SUB_START(SUB_START), .SUB_END(SUB_END),
    .CH_EN(CH_EN), .DWELL(DWELL), .TBL_MODE(TBL_MODE),
    .TBL_A(TBL_A), .TBL_B(TBL_B), .TBL_OK(TBL_OK),
    .A_CTRL(A_CTRL), .B_CTRL(B_CTRL), .POR(POR), .MEAS_EN(MEAS_EN),
    .CUR_SUB(CUR_SUB), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .SKIP_CNT(SKIP_CNT)
  );

  int         done_cycle, done_count, meas_total, por_valid_cnt, por_high_cnt;
  int         dis_bad, por_not_all;
  int         meas_starts[$];
  int         a_at_meas[$];
  int         b_at_meas[$];
  logic       busy_after;
  logic [7:0] min_sub, max_sub;
  logic [NCH-1:0] cur_en;

  task automatic start_sweep(input logic [7:0] m, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [NCH-1:0] en, input logic [DW-1:0] dw);
    @(negedge CLK);
    MAIN_MODE = m; SUB_START = s0; SUB_END = s1; CH_EN = en; DWELL = dw;
    cur_en = en;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the edge that accepted START.
  task automatic run_sweep(input int limit);
    logic prev_meas = 1'b0;
    done_cycle = -1; done_count = 0; meas_total = 0; por_valid_cnt = 0; por_high_cnt = 0;
    dis_bad = 0; por_not_all = 0; busy_after = 1'b1; min_sub = 8'hFF; max_sub = 8'h00;
    meas_starts.delete(); a_at_meas.delete(); b_at_meas.delete();
    for (int n = 1; n <= limit; n++) begin
      @(negedge CLK);
      if (DONE) begin
        done_count++;
        if (done_cycle < 0) done_cycle = n;
      end
      if (done_cycle < 0 || n == done_cycle) begin
        if (MEAS_EN) begin
          meas_total++;
          if (!prev_meas) begin
            meas_starts.push_back(n);
            a_at_meas.push_back(int'(A_CTRL[CW-1:0]));
            b_at_meas.push_back(int'(B_CTRL[CW-1:0]));
          end
        end
        prev_meas = MEAS_EN;
        if (POR[0]) por_high_cnt++;
        if (POR[0] && A_CTRL[CW-1:0] != '0) por_valid_cnt++;
        if (POR != '1) por_not_all++;
        if (CUR_SUB < min_sub) min_sub = CUR_SUB;
        if (CUR_SUB > max_sub) max_sub = CUR_SUB;
        for (int k = 0; k < NCH; k++)
          if (!cur_en[k] && (A_CTRL[k*CW +: CW] != '0 || B_CTRL[k*CW +: CW] != '0 || !POR[k]))
            dis_bad++;
      end
      if (done_cycle > 0 && n == done_cycle + 1) begin
        busy_after = BUSY;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RSTX = 1'b0; START = 1'b0; ABORT = 1'b0;
    MAIN_MODE = '0; SUB_START = '0; SUB_END = '0; CH_EN = '0; DWELL = '0; cur_en = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (POR !== 4'hF) begin n_errors++; $display("[TB] FAIL rst_por: got %h exp F", POR); end
    n_checks++; if (A_CTRL !== '0 || B_CTRL !== '0) begin n_errors++; $display("[TB] FAIL rst_ab: got %h/%h exp 0", A_CTRL, B_CTRL); end
    n_checks++; if ({BUSY, DONE, ERR, MEAS_EN} !== 4'b0) begin n_errors++; $display("[TB] FAIL rst_flags: got %b exp 0000", {BUSY, DONE, ERR, MEAS_EN}); end
    n_checks++; if (TBL_MODE !== 16'd0 || CUR_SUB !== 8'd0 || SKIP_CNT !== 8'd0) begin n_errors++; $display("[TB] FAIL rst_regs: got %h %h %h exp 0", TBL_MODE, CUR_SUB, SKIP_CNT); end
    @(negedge CLK);
    RSTX = 1'b1;
  endtask

  task automatic test_basic_sweep();
    start_sweep(8'd13, 8'd0, 8'd2, 4'b0001, 16'd4);
    run_sweep(200);
    n_checks++; if (done_cycle !== 91) begin n_errors++; $display("[TB] FAIL basic_done_cycle: got %0d exp 91", done_cycle); end
    n_checks++; if (done_count !== 1) begin n_errors++; $display("[TB] FAIL basic_done_count: got %0d exp 1", done_count); end
    n_checks++; if (meas_total !== 12) begin n_errors++; $display("[TB] FAIL basic_meas_total: got %0d exp 12", meas_total); end
    n_checks++; if (meas_starts.size() !== 3) begin n_errors++; $display("[TB] FAIL basic_meas_windows: got %0d exp 3", meas_starts.size()); end
    else begin
      n_checks++; if (meas_starts[0] !== 26 || meas_starts[1] !== 56 || meas_starts[2] !== 86) begin n_errors++; $display("[TB] FAIL basic_meas_pos: got %0d %0d %0d exp 26 56 86", meas_starts[0], meas_starts[1], meas_starts[2]); end
      n_checks++; if (a_at_meas[1] !== 101 || b_at_meas[2] !== 3330) begin n_errors++; $display("[TB] FAIL basic_ctrl_words: got %0d %0d exp 101 3330", a_at_meas[1], b_at_meas[2]); end
    end
    n_checks++; if (por_valid_cnt !== 24) begin n_errors++; $display("[TB] FAIL basic_por_valid: got %0d exp 24", por_valid_cnt); end
    n_checks++; if (por_high_cnt !== 28) begin n_errors++; $display("[TB] FAIL basic_por_high: got %0d exp 28", por_high_cnt); end
    n_checks++; if (dis_bad !== 0) begin n_errors++; $display("[TB] FAIL basic_disabled_unable: got %0d exp 0", dis_bad); end
    n_checks++; if (ERR !== 1'b0 || SKIP_CNT !== 8'd0) begin n_errors++; $display("[TB] FAIL basic_err: got %b %0d exp 0 0", ERR, SKIP_CNT); end
    n_checks++; if (busy_after !== 1'b0 || CUR_SUB !== 8'd2) begin n_errors++; $display("[TB] FAIL basic_end: got busy %b sub %0d exp 0 2", busy_after, CUR_SUB); end
  endtask

  task automatic test_unsupported();
    bad_en = 1'b1; bad_sub = 8'd6;
    start_sweep(8'd13, 8'd5, 8'd7, 4'b0001, 16'd4);
    run_sweep(200);
    bad_en = 1'b0;
    n_checks++; if (done_cycle !== 63) begin n_errors++; $display("[TB] FAIL unsup_done_cycle: got %0d exp 63", done_cycle); end
    n_checks++; if (meas_starts.size() !== 2) begin n_errors++; $display("[TB] FAIL unsup_meas_windows: got %0d exp 2", meas_starts.size()); end
    else begin
      n_checks++; if (meas_starts[1] !== 58 || a_at_meas[0] !== 105 || a_at_meas[1] !== 107) begin n_errors++; $display("[TB] FAIL unsup_meas: got %0d %0d %0d exp 58 105 107", meas_starts[1], a_at_meas[0], a_at_meas[1]); end
    end
    n_checks++; if (por_high_cnt !== 21 || por_valid_cnt !== 16) begin n_errors++; $display("[TB] FAIL unsup_por: got %0d %0d exp 21 16", por_high_cnt, por_valid_cnt); end
    n_checks++; if (SKIP_CNT !== 8'd1 || ERR !== 1'b1) begin n_errors++; $display("[TB] FAIL unsup_err: got %0d %b exp 1 1", SKIP_CNT, ERR); end
  endtask

  task automatic test_range_error();
    start_sweep(8'd13, 8'd9, 8'd3, 4'b1111, 16'd4);
    run_sweep(20);
    n_checks++; if (done_cycle !== 1 || done_count !== 1) begin n_errors++; $display("[TB] FAIL range_done: got %0d %0d exp 1 1", done_cycle, done_count); end
    n_checks++; if (ERR !== 1'b1 || meas_total !== 0) begin n_errors++; $display("[TB] FAIL range_err: got %b %0d exp 1 0", ERR, meas_total); end
    n_checks++; if (por_not_all !== 0 || busy_after !== 1'b0) begin n_errors++; $display("[TB] FAIL range_unable: got %0d busy %b exp 0 0", por_not_all, busy_after); end
  endtask

  task automatic test_abort();
    int rise = -1;
    start_sweep(8'd13, 8'd0, 8'd1, 4'b0011, 16'd4);
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (MEAS_EN) begin rise = n; break; end
    end
    n_checks++; if (rise !== 26) begin n_errors++; $display("[TB] FAIL abort_meas_rise: got %0d exp 26", rise); end
    @(posedge CLK);
    #1 ABORT = 1'b1;
    @(posedge CLK);
    #1 ABORT = 1'b0;
    @(negedge CLK);
    n_checks++; if ({MEAS_EN, DONE, BUSY} !== 3'b011) begin n_errors++; $display("[TB] FAIL abort_fin: got %b exp 011", {MEAS_EN, DONE, BUSY}); end
    n_checks++; if (POR !== 4'hF || A_CTRL !== '0 || ERR !== 1'b0) begin n_errors++; $display("[TB] FAIL abort_unable: got %h %h %b exp F 0 0", POR, A_CTRL, ERR); end
    @(negedge CLK);
    n_checks++; if ({DONE, BUSY} !== 2'b00) begin n_errors++; $display("[TB] FAIL abort_idle: got %b exp 00", {DONE, BUSY}); end
    // START together with ABORT in IDLE must not launch a sweep.
    SUB_START = 8'd40; SUB_END = 8'd41;
    START = 1'b1; ABORT = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0; ABORT = 1'b0;
    rise = 0;
    repeat (5) begin
      @(negedge CLK);
      if (BUSY || DONE) rise++;
    end
    n_checks++; if (rise !== 0 || CUR_SUB !== 8'd0) begin n_errors++; $display("[TB] FAIL abort_start_ignored: got %0d sub %0d exp 0 0", rise, CUR_SUB); end
  endtask

  task automatic test_top_of_range();
    start_sweep(8'd2, 8'd254, 8'd255, 4'b0001, 16'd0);
    run_sweep(200);
    n_checks++; if (done_cycle !== 55 || meas_total !== 2) begin n_errors++; $display("[TB] FAIL top_timing: got %0d %0d exp 55 2", done_cycle, meas_total); end
    n_checks++; if (meas_starts.size() !== 2) begin n_errors++; $display("[TB] FAIL top_meas_windows: got %0d exp 2", meas_starts.size()); end
    else begin
      n_checks++; if (meas_starts[1] !== 53) begin n_errors++; $display("[TB] FAIL top_meas_pos: got %0d exp 53", meas_starts[1]); end
    end
    n_checks++; if (min_sub !== 8'd254 || CUR_SUB !== 8'd255 || done_count !== 1) begin n_errors++; $display("[TB] FAIL top_no_wrap: got min %0d end %0d done %0d exp 254 255 1", min_sub, CUR_SUB, done_count); end
  endtask

  task automatic test_reset_mid_sweep();
    int dn = 0;
    bad_en = 1'b1; bad_sub = 8'd6;
    start_sweep(8'd13, 8'd6, 8'd7, 4'b0001, 16'd4);
    repeat (18) @(negedge CLK);
    n_checks++; if (ERR !== 1'b1 || CUR_SUB !== 8'd7 || POR[0] !== 1'b0) begin n_errors++; $display("[TB] FAIL midrst_pre: got %b %0d %b exp 1 7 0", ERR, CUR_SUB, POR[0]); end
    #2 RSTX = 1'b0;
    #1;
    n_checks++; if (POR !== 4'hF || A_CTRL !== '0 || B_CTRL !== '0) begin n_errors++; $display("[TB] FAIL midrst_async_ab: got %h %h %h exp F 0 0", POR, A_CTRL, B_CTRL); end
    n_checks++; if ({BUSY, DONE, ERR, MEAS_EN} !== 4'b0 || SKIP_CNT !== 8'd0 || CUR_SUB !== 8'd0 || TBL_MODE !== 16'd0) begin n_errors++; $display("[TB] FAIL midrst_async_regs: got %b %0d %0d %h exp 0", {BUSY, DONE, ERR, MEAS_EN}, SKIP_CNT, CUR_SUB, TBL_MODE); end
    repeat (3) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    RSTX = 1'b1;
    bad_en = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE || BUSY) dn++;
    end
    n_checks++; if (dn !== 0) begin n_errors++; $display("[TB] FAIL midrst_no_done: got %0d exp 0", dn); end
    start_sweep(8'd13, 8'd3, 8'd3, 4'b0001, 16'd2);
    run_sweep(100);
    n_checks++; if (done_cycle !== 29 || done_count !== 1 || meas_total !== 2 || ERR !== 1'b0) begin n_errors++; $display("[TB] FAIL midrst_resweep: got %0d %0d %0d %b exp 29 1 2 0", done_cycle, done_count, meas_total, ERR); end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_unsupported();
    test_range_error();
    test_abort();
    test_top_of_range();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
